// File: rtl/jtag_tap_multi_dr.sv
// jtag_tap_multi_dr
//   IEEE 1149.1 TAP controller with a configurable-width instruction register
//   and instruction-selected data chains: BYPASS, IDCODE and NUM_USER_DR user
//   data registers. Each user register has parallel capture inputs, parallel
//   update outputs and a one-tck update strobe.
//
//   Optional build macro: JTAG_TDO_NEGEDGE_EN
//     defined   : tdo/tdo_en are registered on the falling edge of tck
//     undefined : tdo/tdo_en are combinational from state and shift-reg bit0
//
// Ports
//   tck          test clock (all state on the rising edge unless noted)
//   trst_n       asynchronous active-low reset
//   tms, tdi     test mode select / serial data in, sampled on rising tck
//   tdo, tdo_en  serial data out and its valid flag (Shift-IR / Shift-DR)
//   ir_value     currently latched instruction
//   user_dr_in   capture values, slice k belongs to user register k
//   user_dr_out  latched update values, slice k belongs to user register k
//   user_update  one-tck pulse per user register while in Update-DR
//   tap_state    debug view of the TAP state (encoding of tap_state_e)
module jtag_tap_multi_dr #(
  parameter int          IR_WIDTH     = 4,
  parameter int          DR_WIDTH     = 8,
  parameter int          NUM_USER_DR  = 2,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                            tck,
  input  logic                            trst_n,
  input  logic                            tms,
  input  logic                            tdi,
  output logic                            tdo,
  output logic                            tdo_en,
  output logic [IR_WIDTH-1:0]             ir_value,
  input  logic [NUM_USER_DR*DR_WIDTH-1:0] user_dr_in,
  output logic [NUM_USER_DR*DR_WIDTH-1:0] user_dr_out,
  output logic [NUM_USER_DR-1:0]          user_update,
  output logic [3:0]                      tap_state
);

  localparam int SR_W  = (DR_WIDTH > 32) ? DR_WIDTH : 32;
  localparam int IDX_W = (NUM_USER_DR > 1) ? $clog2(NUM_USER_DR) : 1;
  localparam int UW    = NUM_USER_DR * DR_WIDTH;

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,
    SEL_DR = 4'd2,  CAP_DR = 4'd3,  SH_DR  = 4'd4,  EX1_DR = 4'd5,
    PA_DR  = 4'd6,  EX2_DR = 4'd7,  UPD_DR = 4'd8,
    SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11, EX1_IR = 4'd12,
    PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e              state_q, state_d;
  logic [IR_WIDTH-1:0]     ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]     ir_value_q, ir_value_d;
  logic [SR_W-1:0]         dr_sr_q, dr_sr_d;
  logic [UW-1:0]           user_dr_out_q, user_dr_out_d;
  logic [NUM_USER_DR-1:0]  user_update_q, user_update_d;

  logic                    user_hit;
  logic [IDX_W-1:0]        user_idx;
  int                      chain_len;
  logic                    tdo_c, tdo_en_c;

  // TAP next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Instruction decode: IDCODE, USER k, everything else is 1-bit bypass.
  // With 2+NUM_USER_DR < 2^IR_WIDTH-1 the all-ones opcode never hits a user.
  always_comb begin
    user_hit  = 1'b0;
    user_idx  = '0;
    chain_len = 1;
    if (ir_value_q == IR_WIDTH'(1)) chain_len = 32;
    for (int k = 0; k < NUM_USER_DR; k++) begin
      if (ir_value_q == IR_WIDTH'(k + 2)) begin
        user_hit  = 1'b1;
        user_idx  = IDX_W'(k);
        chain_len = DR_WIDTH;
      end
    end
  end

  // IR shift register and latched instruction
  always_comb begin
    ir_sr_d    = ir_sr_q;
    ir_value_d = ir_value_q;
    if (state_q == CAP_IR) ir_sr_d = IR_WIDTH'(1);
    if (state_q == SH_IR)  ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
    if (state_q == UPD_IR) ir_value_d = ir_sr_q;
    // Entering or staying in TLR forces IDCODE.
    if (state_d == TLR)    ir_value_d = IR_WIDTH'(1);
  end

  // DR shift register: one physical register, its active length set by the
  // instruction. tdi lands at bit chain_len-1; anything above is never read.
  always_comb begin
    dr_sr_d = dr_sr_q;
    if (state_q == CAP_DR) begin
      if (user_hit)
        dr_sr_d = SR_W'(user_dr_in[user_idx*DR_WIDTH +: DR_WIDTH]);
      else if (chain_len == 32)
        dr_sr_d = SR_W'(IDCODE_VALUE);
      else
        dr_sr_d = '0;
    end
    if (state_q == SH_DR) begin
      dr_sr_d = {1'b0, dr_sr_q[SR_W-1:1]};
      for (int i = 0; i < SR_W; i++) begin
        if (i == chain_len - 1) dr_sr_d[i] = tdi;
      end
    end
  end

  // User update: latched on the edge entering UPD_DR, so the new value and
  // the strobe are both visible for the whole Update-DR cycle.
  always_comb begin
    user_dr_out_d = user_dr_out_q;
    user_update_d = '0;
    if (state_d == UPD_DR && user_hit) begin
      user_dr_out_d[user_idx*DR_WIDTH +: DR_WIDTH] = dr_sr_q[DR_WIDTH-1:0];
      user_update_d[user_idx] = 1'b1;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q       <= TLR;
      ir_sr_q       <= '0;
      ir_value_q    <= IR_WIDTH'(1);
      dr_sr_q       <= '0;
      user_dr_out_q <= '0;
      user_update_q <= '0;
    end else begin
      state_q       <= state_d;
      ir_sr_q       <= ir_sr_d;
      ir_value_q    <= ir_value_d;
      dr_sr_q       <= dr_sr_d;
      user_dr_out_q <= user_dr_out_d;
      user_update_q <= user_update_d;
    end
  end

  always_comb begin
    tdo_en_c = (state_q == SH_IR) || (state_q == SH_DR);
    tdo_c    = 1'b0;
    if (state_q == SH_IR) tdo_c = ir_sr_q[0];
    if (state_q == SH_DR) tdo_c = dr_sr_q[0];
  end

`ifdef JTAG_TDO_NEGEDGE_EN
  logic tdo_q, tdo_en_q;
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_c;
      tdo_en_q <= tdo_en_c;
    end
  end
  assign tdo    = tdo_q;
  assign tdo_en = tdo_en_q;
`else
  assign tdo    = tdo_c;
  assign tdo_en = tdo_en_c;
`endif

  assign ir_value    = ir_value_q;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;
  assign tap_state   = state_q;

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// tb_jtag_tap_multi_dr
//   Bench for jtag_tap_multi_dr (default parameters). A behavioural model
//   (transition table + bit queues) tracks the TAP and is compared on every
//   tck; a vector table walks all 16 states; hand-written sequences cover
//   IDCODE readout, 5xTMS reset, bypass delay, user update strobes and reset
//   in the middle of a shift.
module tb_jtag_tap_multi_dr;
  localparam int IR_WIDTH = 4;
  localparam int DR_WIDTH = 8;
  localparam int NUM_USER_DR = 2;
  localparam int UW = NUM_USER_DR * DR_WIDTH;
  localparam logic [31:0] IDCODE = 32'h1000_0001;

  // State codes as exposed on tap_state
  localparam int S_TLR = 0, S_RTI = 1, S_SEL_DR = 2, S_CAP_DR = 3, S_SH_DR = 4,
                 S_EX1_DR = 5, S_PA_DR = 6, S_EX2_DR = 7, S_UPD_DR = 8,
                 S_SEL_IR = 9, S_CAP_IR = 10, S_SH_IR = 11, S_EX1_IR = 12,
                 S_PA_IR = 13, S_EX2_IR = 14, S_UPD_IR = 15;

  logic                tck, trst_n, tms, tdi;
  logic                tdo, tdo_en;
  logic [IR_WIDTH-1:0] ir_value;
  logic [UW-1:0]       user_dr_in, user_dr_out;
  logic [NUM_USER_DR-1:0] user_update;
  logic [3:0]          tap_state;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_tap_multi_dr #(
    .IR_WIDTH(IR_WIDTH), .DR_WIDTH(DR_WIDTH),
    .NUM_USER_DR(NUM_USER_DR), .IDCODE_VALUE(IDCODE)
  ) dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .ir_value(ir_value),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out),
    .user_update(user_update), .tap_state(tap_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int nxt_tbl [16][2];
  int m_state;
  int m_ir;
  bit m_irq[$];
  bit m_drq[$];
  logic [DR_WIDTH-1:0] m_uout [NUM_USER_DR];
  logic [NUM_USER_DR-1:0] m_upd;

  function automatic logic [63:0] q2v(input bit q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  function automatic logic [UW-1:0] m_uout_flat();
    logic [UW-1:0] v = '0;
    for (int k = 0; k < NUM_USER_DR; k++) v[k*DR_WIDTH +: DR_WIDTH] = m_uout[k];
    return v;
  endfunction

  function automatic bit m_is_user(input int ir);
    return (ir >= 2) && (ir < 2 + NUM_USER_DR);
  endfunction

  task automatic model_reset();
    m_state = S_TLR;
    m_ir = 1;
    m_irq.delete();
    m_drq.delete();
    for (int k = 0; k < NUM_USER_DR; k++) m_uout[k] = '0;
    m_upd = '0;
  endtask

  task automatic model_step(input bit t_ms, input bit t_di);
    int nx;
    int len;
    logic [63:0] val;
    nx = nxt_tbl[m_state][t_ms];
    m_upd = '0;
    case (m_state)
      S_CAP_IR: begin
        m_irq.delete();
        m_irq.push_back(1'b1);
        for (int i = 1; i < IR_WIDTH; i++) m_irq.push_back(1'b0);
      end
      S_SH_IR: begin
        void'(m_irq.pop_front());
        m_irq.push_back(t_di);
      end
      S_UPD_IR: m_ir = int'(q2v(m_irq));
      S_CAP_DR: begin
        if (m_ir == 1) begin
          len = 32; val = 64'(IDCODE);
        end else if (m_is_user(m_ir)) begin
          len = DR_WIDTH; val = 64'(user_dr_in[(m_ir-2)*DR_WIDTH +: DR_WIDTH]);
        end else begin
          len = 1; val = '0;
        end
        m_drq.delete();
        for (int i = 0; i < len; i++) m_drq.push_back(val[i]);
      end
      S_SH_DR: begin
        void'(m_drq.pop_front());
        m_drq.push_back(t_di);
      end
      default: ;
    endcase
    if (nx == S_UPD_DR && m_is_user(m_ir)) begin
      m_uout[m_ir-2] = DR_WIDTH'(q2v(m_drq));
      m_upd[m_ir-2]  = 1'b1;
    end
    if (nx == S_TLR) m_ir = 1;
    m_state = nx;
  endtask

  // ---------------- driver tasks ----------------
  // One tck: drive at negedge, sample tdo just before the rising edge,
  // step the model, then compare registered outputs just after the edge.
  task automatic tick(input bit t_ms, input bit t_di, output bit tdo_seen, output bit en_seen);
    bit exp_en, exp_tdo;
    @(negedge tck);
    tms = t_ms;
    tdi = t_di;
    #4;
    exp_en  = (m_state == S_SH_DR) || (m_state == S_SH_IR);
    exp_tdo = 1'b0;
    if (m_state == S_SH_IR && m_irq.size() > 0) exp_tdo = m_irq[0];
    if (m_state == S_SH_DR && m_drq.size() > 0) exp_tdo = m_drq[0];
    tdo_seen = tdo;
    en_seen  = tdo_en;
    check("m_tdo_en", 64'(tdo_en), 64'(exp_en));
    check("m_tdo", 64'(tdo), 64'(exp_tdo));
    model_step(t_ms, t_di);
    @(posedge tck);
    #1;
    check("m_state", 64'(tap_state), 64'(m_state));
    check("m_ir", 64'(ir_value), 64'(m_ir));
    check("m_user_out", 64'(user_dr_out), 64'(m_uout_flat()));
    check("m_user_upd", 64'(user_update), 64'(m_upd));
  endtask

  task automatic do_reset();
    #1;
    trst_n = 1'b0;
    model_reset();
    #1;
    check("rst_state", 64'(tap_state), 64'(S_TLR));
    check("rst_ir", 64'(ir_value), 64'd1);
    check("rst_user_out", 64'(user_dr_out), 64'd0);
    check("rst_user_upd", 64'(user_update), 64'd0);
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_tdo_en", 64'(tdo_en), 64'd0);
    #1;
    trst_n = 1'b1;
  endtask

  // From RTI: shift an IR value, finish back in RTI. Returns bits seen on tdo.
  task automatic shift_ir(input logic [IR_WIDTH-1:0] v, output logic [IR_WIDTH-1:0] dout);
    bit t, e;
    tick(1, 0, t, e); tick(1, 0, t, e); tick(0, 0, t, e); tick(0, 0, t, e);
    for (int i = 0; i < IR_WIDTH; i++) begin
      tick(i == IR_WIDTH-1, v[i], t, e);
      dout[i] = t;
    end
    tick(1, 0, t, e);
    tick(0, 0, t, e);
  endtask

  // From RTI: shift n DR bits, pass through UPD_DR back to RTI. uo/uu are the
  // user outputs observed during the Update-DR cycle.
  task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                          output logic [UW-1:0] uo, output logic [NUM_USER_DR-1:0] uu);
    bit t, e;
    dout = '0;
    tick(1, 0, t, e); tick(0, 0, t, e); tick(0, 0, t, e);
    for (int i = 0; i < n; i++) begin
      tick(i == n-1, din[i], t, e);
      dout[i] = t;
    end
    tick(1, 0, t, e);
    uo = user_dr_out;
    uu = user_update;
    tick(0, 0, t, e);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    bit         tms;
    bit         tdi;
    logic [3:0] st;   // state after the edge
    bit         en;   // tdo_en before the edge
    bit         tdo;  // tdo before the edge
    logic [3:0] ir;   // ir_value after the edge
  } vec_t;

  vec_t vecs [25];

  initial begin
    logic [63:0] dout;
    logic [IR_WIDTH-1:0] irout;
    logic [UW-1:0] uo;
    logic [NUM_USER_DR-1:0] uu;
    bit t, e;

    nxt_tbl = '{'{S_RTI, S_TLR}, '{S_RTI, S_SEL_DR}, '{S_CAP_DR, S_SEL_IR},
                '{S_SH_DR, S_EX1_DR}, '{S_SH_DR, S_EX1_DR}, '{S_PA_DR, S_UPD_DR},
                '{S_PA_DR, S_EX2_DR}, '{S_SH_DR, S_UPD_DR}, '{S_RTI, S_SEL_DR},
                '{S_CAP_IR, S_TLR}, '{S_SH_IR, S_EX1_IR}, '{S_SH_IR, S_EX1_IR},
                '{S_PA_IR, S_UPD_IR}, '{S_PA_IR, S_EX2_IR}, '{S_SH_IR, S_UPD_IR},
                '{S_RTI, S_SEL_DR}};

    vecs[0]  = '{0, 0, S_RTI,    0, 0, 1};
    vecs[1]  = '{1, 0, S_SEL_DR, 0, 0, 1};
    vecs[2]  = '{0, 0, S_CAP_DR, 0, 0, 1};
    vecs[3]  = '{0, 0, S_SH_DR,  0, 0, 1};
    vecs[4]  = '{1, 0, S_EX1_DR, 1, 1, 1};
    vecs[5]  = '{0, 0, S_PA_DR,  0, 0, 1};
    vecs[6]  = '{1, 0, S_EX2_DR, 0, 0, 1};
    vecs[7]  = '{0, 0, S_SH_DR,  0, 0, 1};
    vecs[8]  = '{1, 0, S_EX1_DR, 1, 0, 1};
    vecs[9]  = '{1, 0, S_UPD_DR, 0, 0, 1};
    vecs[10] = '{1, 0, S_SEL_DR, 0, 0, 1};
    vecs[11] = '{1, 0, S_SEL_IR, 0, 0, 1};
    vecs[12] = '{0, 0, S_CAP_IR, 0, 0, 1};
    vecs[13] = '{0, 0, S_SH_IR,  0, 0, 1};
    vecs[14] = '{1, 0, S_EX1_IR, 1, 1, 1};
    vecs[15] = '{0, 0, S_PA_IR,  0, 0, 1};
    vecs[16] = '{1, 0, S_EX2_IR, 0, 0, 1};
    vecs[17] = '{0, 0, S_SH_IR,  0, 0, 1};
    vecs[18] = '{1, 1, S_EX1_IR, 1, 0, 1};
    vecs[19] = '{1, 0, S_UPD_IR, 0, 0, 1};
    vecs[20] = '{0, 0, S_RTI,    0, 0, 8};
    vecs[21] = '{1, 0, S_SEL_DR, 0, 0, 8};
    vecs[22] = '{1, 0, S_SEL_IR, 0, 0, 8};
    vecs[23] = '{1, 0, S_TLR,    0, 0, 1};
    vecs[24] = '{1, 0, S_TLR,    0, 0, 1};

    trst_n = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    user_dr_in = '0;
    model_reset();
    @(posedge tck);
    do_reset();

    // State walk through all 16 states
    for (int i = 0; i < 25; i++) begin
      tick(vecs[i].tms, vecs[i].tdi, t, e);
      check("vec_en", 64'(e), 64'(vecs[i].en));
      check("vec_tdo", 64'(t), 64'(vecs[i].tdo));
      check("vec_state", 64'(tap_state), 64'(vecs[i].st));
      check("vec_ir", 64'(ir_value), 64'(vecs[i].ir));
    end

    // IDCODE readout straight after reset
    do_reset();
    tick(0, 0, t, e);
    shift_dr(32, 64'd0, dout, uo, uu);
    check("idcode_read", dout, 64'h1000_0001);
    check("idcode_ir", 64'(ir_value), 64'd1);

    // 5 x TMS=1 from SH_DR and from PA_IR, with a non-IDCODE IR loaded
    shift_ir(4'd3, irout);
    tick(1, 0, t, e); tick(0, 0, t, e); tick(0, 0, t, e);
    for (int i = 0; i < 5; i++) tick(1, 0, t, e);
    check("tlr_from_shdr_state", 64'(tap_state), 64'(S_TLR));
    check("tlr_from_shdr_ir", 64'(ir_value), 64'd1);
    check("tlr_from_shdr_en", 64'(tdo_en), 64'd0);
    tick(0, 0, t, e);
    tick(1, 0, t, e); tick(1, 0, t, e); tick(0, 0, t, e); tick(0, 0, t, e);
    tick(1, 0, t, e); tick(0, 0, t, e);
    check("pa_ir_state", 64'(tap_state), 64'(S_PA_IR));
    for (int i = 0; i < 5; i++) tick(1, 1, t, e);
    check("tlr_from_pair_state", 64'(tap_state), 64'(S_TLR));
    check("tlr_from_pair_ir", 64'(ir_value), 64'd1);
    tick(0, 0, t, e);

    // BYPASS (all ones): one-bit delay, user outputs untouched
    shift_ir(4'b1111, irout);
    check("ir_capture_bypass", 64'(irout), 64'b0001);
    shift_dr(9, 64'h0A5, dout, uo, uu);
    check("bypass_delay", dout, 64'h14A);
    check("bypass_user_out", 64'(uo), 64'd0);
    check("bypass_user_upd", 64'(uu), 64'd0);

    // USER0 capture/update, then a second pass with its own pulse
    user_dr_in = 16'h003C;
    shift_ir(4'd2, irout);
    shift_dr(8, 64'hA5, dout, uo, uu);
    check("user0_capture", dout, 64'h3C);
    check("user0_out", 64'(uo), 64'h00A5);
    check("user0_upd", 64'(uu), 64'b01);
    check("user0_upd_gone", 64'(user_update), 64'd0);
    shift_dr(8, 64'h0F, dout, uo, uu);
    check("user0_recapture", dout, 64'h3C);
    check("user0_out2", 64'(uo), 64'h000F);
    check("user0_upd2", 64'(uu), 64'b01);

    // IR captured pattern and unused opcodes behave as bypass
    shift_ir(4'b0000, irout);
    check("ir_capture_pattern", 64'(irout), 64'b0001);
    check("ir_zero", 64'(ir_value), 64'd0);
    shift_dr(9, 64'h1C3, dout, uo, uu);
    check("op0_bypass", dout, 64'h186);
    shift_ir(4'b0111, irout);
    shift_dr(9, 64'h0A5, dout, uo, uu);
    check("op7_bypass", dout, 64'h14A);
    check("op7_user_out", 64'(uo), 64'h000F);

    // USER1 update, then reset in the middle of a USER1 shift
    user_dr_in = 16'h7700;
    shift_ir(4'd3, irout);
    shift_dr(8, 64'h5A, dout, uo, uu);
    check("user1_capture", dout, 64'h77);
    check("user1_out", 64'(uo), 64'h5A0F);
    check("user1_upd", 64'(uu), 64'b10);
    tick(1, 0, t, e); tick(0, 0, t, e); tick(0, 0, t, e);
    for (int i = 0; i < 4; i++) tick(0, 1, t, e);
    do_reset();
    tick(0, 0, t, e);
    shift_dr(32, 64'd0, dout, uo, uu);
    check("idcode_after_rst", dout, 64'h1000_0001);
    check("idcode_after_rst_out", 64'(uo), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) user_dr_in = UW'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      tick($urandom_range(0, 99) < 30, 1'($urandom), t, e);
    end
    // Directed-random user updates
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      int k;
      k = $urandom_range(0, NUM_USER_DR-1);
      d = 8'($urandom);
      user_dr_in = UW'($urandom);
      tick(1, 0, t, e); tick(1, 0, t, e); tick(1, 0, t, e); tick(1, 0, t, e); tick(1, 0, t, e);
      tick(0, 0, t, e);
      shift_ir(IR_WIDTH'(k + 2), irout);
      shift_dr(8, 64'(d), dout, uo, uu);
      check("rnd_user_out", 64'(uo[k*DR_WIDTH +: DR_WIDTH]), 64'(d));
      check("rnd_user_upd", 64'(uu), 64'(1 << k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
